// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - multi-channel SRAM request arbiter with in-order response routing
//
// Channels present requests on packed slices. One channel is granted and
// forwarded to the single downstream SRAM port. Accepted channel ids are kept
// in an in-order tag FIFO so that each downstream response can be steered
// back to the channel that issued the request.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration; after channel k
//                                    is accepted, k+1 (mod NCH) becomes the
//                                    highest priority.
//                       undefined -> fixed priority, channel 0 highest.
//
// Ports:
//   clk           clock, all state on the rising edge
//   reset         asynchronous active-high reset
//   ch_req        per-channel request
//   ch_wr         per-channel write flag (1 = write)
//   ch_wstrb      per-channel byte enables, packed NCH x DW/8
//   ch_addr       per-channel address, packed NCH x AW
//   ch_wdata      per-channel write data, packed NCH x DW
//   ch_addr_ok    one-hot: request of that channel accepted this cycle
//   ch_data_ok    one-hot: response for that channel returned this cycle
//   ch_rdata      read data, broadcast to all channels
//   mem_req       downstream request
//   mem_wr        downstream write flag
//   mem_wstrb     downstream byte enables
//   mem_addr      downstream address
//   mem_wdata     downstream write data
//   mem_addr_ok   downstream accepts the request when mem_req is high
//   mem_data_ok   downstream response (in request order, writes included)
//   mem_rdata     downstream read data
//   outstanding   number of accepted requests still awaiting a response
//   err_spurious  sticky: a response arrived with no request in flight

module sram_req_arbiter #(
    parameter int NCH   = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCH-1:0]            ch_req,
    input  logic [NCH-1:0]            ch_wr,
    input  logic [NCH*(DW/8)-1:0]     ch_wstrb,
    input  logic [NCH*AW-1:0]         ch_addr,
    input  logic [NCH*DW-1:0]         ch_wdata,
    output logic [NCH-1:0]            ch_addr_ok,
    output logic [NCH-1:0]            ch_data_ok,
    output logic [DW-1:0]             ch_rdata,
    output logic                      mem_req,
    output logic                      mem_wr,
    output logic [DW/8-1:0]           mem_wstrb,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic                      mem_addr_ok,
    input  logic                      mem_data_ok,
    input  logic [DW-1:0]             mem_rdata,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                      err_spurious
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = DW / 8;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state;
    logic [GW-1:0]  lock_grant;
    logic [GW-1:0]  arb_grant;
    logic [GW-1:0]  grant;
    logic           any_req;
    logic           accept;
    logic           fifo_empty;
    logic           pop;

    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [GW-1:0]  tags [DEPTH];
    logic [GW-1:0]  head;

    assign any_req = |ch_req;

    // ------------------------------------------------------------------
    // Arbitration (used only while FREE)
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0]      prio;
    logic [2*NCH-1:0]   rot;
    logic               found;
    int                 sel;

    // Rotate the request vector so that bit 0 is the current priority
    // holder; the first set bit then maps back to a channel id.
    always_comb begin
        rot       = {ch_req, ch_req} >> prio;
        arb_grant = prio;
        found     = 1'b0;
        sel       = 0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sel   = int'(prio) + i;
                if (sel >= NCH) begin
                    sel = sel - NCH;
                end
                arb_grant = GW'(sel);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= '0;
        end else if (accept) begin
            if (grant == GW'(NCH - 1)) begin
                prio <= '0;
            end else begin
                prio <= grant + 1'b1;
            end
        end
    end
`else
    // Scan downwards so the lowest requesting index wins.
    always_comb begin
        arb_grant = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                arb_grant = GW'(i);
            end
        end
    end
`endif

    // A request that was presented but not yet accepted keeps its grant so
    // the downstream sees a stable address until it takes it.
    assign grant = (state == LOCKED) ? lock_grant : arb_grant;

    // ------------------------------------------------------------------
    // Downstream request path (purely combinational from the channels)
    // ------------------------------------------------------------------
    assign mem_req = (any_req || (state == LOCKED)) && (outstanding < FULL_CNT) && !reset;
    assign accept  = mem_req && mem_addr_ok;

    always_comb begin
        mem_wr    = 1'b0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == GW'(i)) begin
                mem_wr    = ch_wr[i];
                mem_wstrb = ch_wstrb[i*SW +: SW];
                mem_addr  = ch_addr[i*AW +: AW];
                mem_wdata = ch_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ch_addr_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_addr_ok[i] = accept && (grant == GW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Response path: head of the tag FIFO names the channel to notify
    // ------------------------------------------------------------------
    assign fifo_empty = (outstanding == '0);
    assign pop        = mem_data_ok && !fifo_empty && !reset;
    assign head       = tags[rd_ptr];
    assign ch_rdata   = mem_rdata;

    always_comb begin
        ch_data_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_data_ok[i] = pop && (head == GW'(i));
        end
    end

    // Tag storage needs no reset: entries are only read behind rd_ptr,
    // which never passes wr_ptr.
    always_ff @(posedge clk) begin
        if (accept) begin
            tags[wr_ptr] <= grant;
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM, pointers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FREE;
            lock_grant   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
            err_spurious <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (mem_req && !mem_addr_ok) begin
                        state      <= LOCKED;
                        lock_grant <= grant;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        state <= FREE;
                    end
                end
                default: state <= FREE;
            endcase

            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // Full blocks mem_req, so a pop in a full cycle only decrements;
            // the waiting request is taken on the next cycle.
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (mem_data_ok && fifo_empty) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameters: NCH, default 2, number of requesting channels (1..8); AW, default 32, address width; DW, default 32, data width; DEPTH, default 4, maximum outstanding requests (power of 2, >=2).
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: ch_req  in  NCH  per-channel request; ch_wr  in  NCH  1=write; ch_wstrb  in  NCH*DW/8  packed byte enables; ch_addr  in  NCH*AW  packed; ch_wdata  in  NCH*DW  packed.
REQ-005 SHALL have ports: ch_addr_ok  out  NCH  request accepted; ch_data_ok  out  NCH  response returned; ch_rdata  out  DW  broadcast read data.
REQ-006 SHALL have ports: mem_req  out  1; mem_wr  out  1; mem_wstrb  out  DW/8; mem_addr  out  AW; mem_wdata  out  DW; mem_addr_ok  in  1; mem_data_ok  in  1; mem_rdata  in  DW.
REQ-007 SHALL have ports: outstanding  out  clog2(DEPTH+1)  in-flight count; err_spurious  out  1  sticky flag.

Function
REQ-008 SHALL treat a downstream acceptance as mem_req & mem_addr_ok, and a downstream response as mem_data_ok; responses arrive in request order; writes also receive a response.
REQ-009 SHALL assert mem_req iff (any ch_req, or lock set) and outstanding < DEPTH and reset low.
REQ-010 SHALL drive mem_wr, mem_wstrb, mem_addr and mem_wdata from the granted channel's slice; ch_addr_ok[g] = mem_req & mem_addr_ok for granted channel g only, all other bits 0.
REQ-011 SHALL use a two-state grant FSM: FREE (grant computed combinationally each cycle) and LOCKED (grant held in a register).
REQ-012 SHALL transition FREE->LOCKED when mem_req=1 and mem_addr_ok=0, latching the current grant; LOCKED->FREE on acceptance. While LOCKED, changes in other ch_req bits SHALL NOT alter the grant.
REQ-013 SHALL push the granted channel id into an in-order tag FIFO of DEPTH entries on acceptance.
REQ-014 SHALL pop the FIFO on mem_data_ok when non-empty, asserting ch_data_ok[head] for that cycle only; ch_rdata = mem_rdata combinationally.
REQ-015 SHALL update outstanding as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-016 SHALL block new acceptance when outstanding = DEPTH, even if a pop occurs in the same cycle; acceptance resumes the following cycle.
REQ-017 SHALL, on mem_data_ok with an empty FIFO, assert no ch_data_ok, leave the count unchanged, and set err_spurious until reset.
REQ-018 SHALL have a combinational request-to-mem_req path, with no added latency, and a zero-cycle path from mem_data_ok to ch_data_ok.

Reset
REQ-019 SHALL, while reset is high, clear FIFO pointers, outstanding, the lock, and err_spurious, set the priority pointer to channel 0, and hold mem_req=0, ch_addr_ok=0 and ch_data_ok=0.
REQ-020 SHALL, when reset is asserted mid-transaction, discard all in-flight tags; responses after reset release are treated as spurious.

Configuration
REQ-021 With ARB_ROUND_ROBIN_EN defined, the block SHALL use round-robin arbitration: after channel k is accepted, highest priority moves to (k+1) mod NCH.
REQ-022 Without ARB_ROUND_ROBIN_EN, the block SHALL use fixed priority, with channel 0 highest, and the priority pointer SHALL be absent.

Verification (NCH=2, DEPTH=4)
REQ-023 Scenario: ch_req=2'b11, mem_addr_ok held 1, round-robin build -> grants 0,1,0,1 over four cycles. Fixed-priority build -> grants 0,0,0,0 and outstanding reaches 4 after the fourth accept.
REQ-024 Scenario: ch_req[1]=1, addr 0x1000, mem_addr_ok=0 for 3 cycles; ch_req[0] rises in cycle 2 -> mem_addr stays 0x1000 and the grant stays 1 until acceptance.
REQ-025 Scenario: accept ch0, ch1, ch0, then three mem_data_ok with rdata 0xA,0xB,0xC -> ch_data_ok sequence 01,10,01, with ch_rdata matching each.
REQ-026 Scenario: fill to outstanding=4, then mem_data_ok and a pending request in the same cycle -> no accept that cycle, outstanding=3; accept next cycle, outstanding=4.
REQ-027 Scenario: mem_data_ok=1 with FIFO empty -> ch_data_ok=0, outstanding=0, err_spurious=1 persisting until reset.
REQ-028 Scenario: reset pulsed with outstanding=2 -> outstanding=0 and mem_req=0 during reset; the next mem_data_ok sets err_spurious.
